bcd_clock_counter: RTL and testbench
====================================

BCD_CLOCK_COUNTER -- requirements
Module: bcd_clock_counter

Interface
REQ-001 Parameter SECONDS, default 1: 1 = hh:mm:ss counter, en steps seconds; 0 = hh:mm counter, en steps minutes, seconds logic absent.
REQ-002 Parameter RST_HOUR, default 0: hour (0-23, binary) loaded at reset; minutes and seconds reset to 00.
REQ-003 Reset scheme: one clock; reset is asynchronous and active-low; clock port clk, reset port rst_n.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 en  in  1  step enable; one step per clk while high.
REQ-007 dir  in  1  0 = count up, 1 = count down.
REQ-008 load  in  1  synchronous load of ld_* digits.
REQ-009 ld_s_u / ld_s_t / ld_m_u / ld_m_t / ld_h_u / ld_h_t  in  4/3/4/3/4/2  load digits, 24h BCD.
REQ-010 mode_12h  in  1  selects 12h hour presentation on h_u/h_t/pm.
REQ-011 s_u / s_t / m_u / m_t  out  4/3/4/3  second and minute BCD digits.
REQ-012 h_u / h_t  out  4/2  hour BCD digits, 24h or 12h per mode_12h.
REQ-013 pm  out  1  1 = PM in 12h mode; 0 in 24h mode.
REQ-014 wrap  out  1  one-cycle pulse on day wrap.
REQ-015 load_err  out  1  one-cycle pulse on rejected load.

Function
REQ-016 Internal time SHALL be held as 24h BCD digits; s_u/s_t/m_u/m_t SHALL be those registers directly.
REQ-017 Up step SHALL increment s_u 0-9, carry to s_t 0-5, to m_u 0-9, to m_t 0-5, to hour 00-23; carries resolved in the same cycle (no ripple latency).
REQ-018 Down step SHALL decrement with borrow: 0 digit reloads its max (9/5/9/5), hour 00 borrows to 23.
REQ-019 Up from 23:59:59 (SECONDS=0: 23:59) SHALL produce 00:00:00 and wrap=1 in the following cycle only.
REQ-020 Down from 00:00:00 SHALL produce 23:59:59 and wrap=1 in the following cycle only.
REQ-021 wrap and load_err SHALL be registered, asserted in the cycle after the triggering edge for exactly one cycle.
REQ-022 load SHALL have priority over en; load with en high SHALL perform no step that cycle.
REQ-023 Load SHALL be legal only if s_u,m_u,h_u<=9, s_t,m_t<=5 and hour<=23; legal load updates all digits on the next edge.
REQ-024 Illegal load SHALL leave all time state unchanged and pulse load_err.
REQ-025 With SECONDS=0, ld_s_* SHALL be ignored for legality and update; s_u/s_t SHALL read 0.
REQ-026 en low and load low SHALL hold all state; dir may change any cycle and applies to the step on that edge.
REQ-027 12h presentation, combinational from hour register: 0 -> 12 AM; 1-11 -> same, AM; 12 -> 12 PM; 13-23 -> hour-12, PM.
REQ-028 mode_12h SHALL affect only h_u/h_t/pm, never the count; toggling it SHALL change outputs without latency.
REQ-029 wrap SHALL depend only on the 24h count, independent of mode_12h.

Reset
REQ-030 rst_n low SHALL immediately force hour=RST_HOUR, minutes/seconds=00, wrap=0, load_err=0, irrespective of clk.
REQ-031 Reset mid-step or mid-load SHALL discard the pending operation; first step counts from reset value after rst_n rises.
REQ-032 No state other than REQ-030 items; no reset-derived internal pulses may block counting after release.

Verification
REQ-033 SECONDS=1, load 23:59:58, en=1 dir=0 for 3 clks -> 23:59:59, 00:00:00 with wrap=1 one cycle, 00:00:01 wrap=0.
REQ-034 Load 00:00:00, en=1 dir=1 one clk -> 23:59:59, wrap=1 one cycle; next down step -> 23:59:58.
REQ-035 Load 24:00:00 or ld_m_t=6 -> load_err=1 one cycle, time unchanged; load with en=1 -> loaded value, no step.
REQ-036 mode_12h=1, load 00:30:00 -> h=12 pm=0; 12:00:00 -> 12 pm=1; 13:05:00 -> 01 pm=1; mode_12h=0 -> 13 pm=0 same cycle.
REQ-037 SECONDS=0, load 09:59, one up step -> 10:00, s_u=s_t=0; RST_HOUR=7 reset -> 07:00.
REQ-038 Assert rst_n low between clk edges during counting -> outputs reset asynchronously; release -> counting resumes from reset value with no lost or extra step.

Source files
------------

// File: rtl/bcd_clock_counter.sv
// Time-of-day counter holding 24h BCD digits, with up/down stepping, checked
// parallel load, day-wrap pulse and a combinational 12h hour presentation.
module bcd_clock_counter #(
    parameter int SECONDS  = 1,
    parameter int RST_HOUR = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] ld_s_u,
    input  logic [2:0] ld_s_t,
    input  logic [3:0] ld_m_u,
    input  logic [2:0] ld_m_t,
    input  logic [3:0] ld_h_u,
    input  logic [1:0] ld_h_t,
    input  logic       mode_12h,
    output logic [3:0] s_u,
    output logic [2:0] s_t,
    output logic [3:0] m_u,
    output logic [2:0] m_t,
    output logic [3:0] h_u,
    output logic [1:0] h_t,
    output logic       pm,
    output logic       wrap,
    output logic       load_err
);

    localparam bit         HAS_SEC = (SECONDS != 0);
    localparam logic [1:0] RST_HT  = 2'(RST_HOUR / 10);
    localparam logic [3:0] RST_HU  = 4'(RST_HOUR % 10);

    logic [3:0] sU, mU, hU, nSU, nMU, nHU;
    logic [2:0] sT, mT, nST, nMT;
    logic [1:0] hT, nHT;
    logic       nWrap, nErr;
    logic       secMax, secZero, minMax, minZero, hourMax, hourZero;
    logic       ldHourOk, ldSecOk, ldOk;

    // Without seconds the seconds field behaves as permanently at both ends,
    // so every step carries/borrows straight into the minutes.
    assign secMax   = HAS_SEC ? (sU == 4'd9 && sT == 3'd5) : 1'b1;
    assign secZero  = HAS_SEC ? (sU == 4'd0 && sT == 3'd0) : 1'b1;
    assign minMax   = (mU == 4'd9) && (mT == 3'd5);
    assign minZero  = (mU == 4'd0) && (mT == 3'd0);
    assign hourMax  = (hT == 2'd2) && (hU == 4'd3);
    assign hourZero = (hT == 2'd0) && (hU == 4'd0);

    assign ldHourOk = (ld_h_t == 2'd2) ? (ld_h_u <= 4'd3)
                                       : ((ld_h_t < 2'd2) && (ld_h_u <= 4'd9));
    assign ldSecOk  = !HAS_SEC || ((ld_s_u <= 4'd9) && (ld_s_t <= 3'd5));
    assign ldOk     = ldSecOk && (ld_m_u <= 4'd9) && (ld_m_t <= 3'd5) && ldHourOk;

    always_comb begin
        nSU   = sU;
        nST   = sT;
        nMU   = mU;
        nMT   = mT;
        nHU   = hU;
        nHT   = hT;
        nWrap = 1'b0;
        nErr  = 1'b0;
        if (load) begin
            if (ldOk) begin
                nSU = HAS_SEC ? ld_s_u : 4'd0;
                nST = HAS_SEC ? ld_s_t : 3'd0;
                nMU = ld_m_u;
                nMT = ld_m_t;
                nHU = ld_h_u;
                nHT = ld_h_t;
            end else begin
                nErr = 1'b1;
            end
        end else if (en) begin
            if (!dir) begin
                if (HAS_SEC) begin
                    nSU = (sU == 4'd9) ? 4'd0 : sU + 4'd1;
                    if (sU == 4'd9)
                        nST = (sT == 3'd5) ? 3'd0 : sT + 3'd1;
                end
                if (secMax) begin
                    nMU = (mU == 4'd9) ? 4'd0 : mU + 4'd1;
                    if (mU == 4'd9)
                        nMT = (mT == 3'd5) ? 3'd0 : mT + 3'd1;
                end
                if (secMax && minMax) begin
                    if (hourMax) begin
                        nHU = 4'd0;
                        nHT = 2'd0;
                    end else if (hU == 4'd9) begin
                        nHU = 4'd0;
                        nHT = hT + 2'd1;
                    end else begin
                        nHU = hU + 4'd1;
                    end
                end
                nWrap = secMax && minMax && hourMax;
            end else begin
                if (HAS_SEC) begin
                    nSU = (sU == 4'd0) ? 4'd9 : sU - 4'd1;
                    if (sU == 4'd0)
                        nST = (sT == 3'd0) ? 3'd5 : sT - 3'd1;
                end
                if (secZero) begin
                    nMU = (mU == 4'd0) ? 4'd9 : mU - 4'd1;
                    if (mU == 4'd0)
                        nMT = (mT == 3'd0) ? 3'd5 : mT - 3'd1;
                end
                if (secZero && minZero) begin
                    if (hourZero) begin
                        nHU = 4'd3;
                        nHT = 2'd2;
                    end else if (hU == 4'd0) begin
                        nHU = 4'd9;
                        nHT = hT - 2'd1;
                    end else begin
                        nHU = hU - 4'd1;
                    end
                end
                nWrap = secZero && minZero && hourZero;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sU       <= 4'd0;
            sT       <= 3'd0;
            mU       <= 4'd0;
            mT       <= 3'd0;
            hU       <= RST_HU;
            hT       <= RST_HT;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            sU       <= nSU;
            sT       <= nST;
            mU       <= nMU;
            mT       <= nMT;
            hU       <= nHU;
            hT       <= nHT;
            wrap     <= nWrap;
            load_err <= nErr;
        end
    end

    logic [4:0] hourBin;
    logic [3:0] hour12;

    assign hourBin = {hT, 3'b000} + {2'b00, hT, 1'b0} + {1'b0, hU};

    // 00 shows as 12 AM; 13..23 fold down by twelve.
    always_comb begin
        if (hourBin == 5'd0)
            hour12 = 4'd12;
        else if (hourBin > 5'd12)
            hour12 = 4'(hourBin - 5'd12);
        else
            hour12 = hourBin[3:0];
    end

    assign s_u = sU;
    assign s_t = sT;
    assign m_u = mU;
    assign m_t = mT;
    assign h_u = mode_12h ? ((hour12 >= 4'd10) ? hour12 - 4'd10 : hour12) : hU;
    assign h_t = mode_12h ? ((hour12 >= 4'd10) ? 2'd1 : 2'd0) : hT;
    assign pm  = mode_12h && (hourBin >= 5'd12);

endmodule

// File: tb/tb_bcd_clock_counter.sv
// Bench for bcd_clock_counter: one instance with seconds (RST_HOUR=0), one without (RST_HOUR=7).
module tb_bcd_clock_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, dir, load, mode_12h;
    logic [3:0] ld_s_u, ld_m_u, ld_h_u;
    logic [2:0] ld_s_t, ld_m_t;
    logic [1:0] ld_h_t;

    logic [3:0] s_u_a, m_u_a, h_u_a, s_u_b, m_u_b, h_u_b;
    logic [2:0] s_t_a, m_t_a, s_t_b, m_t_b;
    logic [1:0] h_t_a, h_t_b;
    logic       pm_a, wrap_a, err_a, pm_b, wrap_b, err_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_clock_counter #(.SECONDS(1), .RST_HOUR(0)) dutA (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
        .ld_s_u(ld_s_u), .ld_s_t(ld_s_t), .ld_m_u(ld_m_u), .ld_m_t(ld_m_t),
        .ld_h_u(ld_h_u), .ld_h_t(ld_h_t), .mode_12h(mode_12h),
        .s_u(s_u_a), .s_t(s_t_a), .m_u(m_u_a), .m_t(m_t_a),
        .h_u(h_u_a), .h_t(h_t_a), .pm(pm_a), .wrap(wrap_a), .load_err(err_a)
    );

    bcd_clock_counter #(.SECONDS(0), .RST_HOUR(7)) dutB (
        .clk(clk), .rst_n(rst_n), .en(en), .dir(dir), .load(load),
        .ld_s_u(ld_s_u), .ld_s_t(ld_s_t), .ld_m_u(ld_m_u), .ld_m_t(ld_m_t),
        .ld_h_u(ld_h_u), .ld_h_t(ld_h_t), .mode_12h(mode_12h),
        .s_u(s_u_b), .s_t(s_t_b), .m_u(m_u_b), .m_t(m_t_b),
        .h_u(h_u_b), .h_t(h_t_b), .pm(pm_b), .wrap(wrap_b), .load_err(err_b)
    );

    // Model: A is seconds-of-day, B is minutes-of-day.
    int tA = 0;
    int tB = 7 * 60;
    bit wrapA = 0, errA = 0, wrapB = 0, errB = 0;

    always @(posedge clk or negedge rst_n) begin
        int h, m, s;
        bit okBase, okSec;
        if (!rst_n) begin
            tA = 0; tB = 7 * 60;
            wrapA = 0; errA = 0; wrapB = 0; errB = 0;
        end else begin
            wrapA = 0; errA = 0; wrapB = 0; errB = 0;
            if (load) begin
                h = int'(ld_h_t) * 10 + int'(ld_h_u);
                m = int'(ld_m_t) * 10 + int'(ld_m_u);
                s = int'(ld_s_t) * 10 + int'(ld_s_u);
                okBase = (ld_m_u <= 9) && (ld_m_t <= 5) && (ld_h_u <= 9) && (h <= 23);
                okSec  = (ld_s_u <= 9) && (ld_s_t <= 5);
                if (okBase && okSec) tA = h * 3600 + m * 60 + s; else errA = 1;
                if (okBase) tB = h * 60 + m; else errB = 1;
            end else if (en) begin
                if (!dir) begin
                    wrapA = (tA == 86399); tA = (tA + 1) % 86400;
                    wrapB = (tB == 1439);  tB = (tB + 1) % 1440;
                end else begin
                    wrapA = (tA == 0); tA = (tA + 86399) % 86400;
                    wrapB = (tB == 0); tB = (tB + 1439) % 1440;
                end
            end
        end
    end

    function automatic logic [22:0] expVec(int h, int m, int s, bit md, bit w, bit e);
        int hh;
        bit p;
        hh = h;
        p  = 0;
        if (md) begin
            p  = (h >= 12);
            hh = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
        end
        return {4'(s % 10), 3'(s / 10), 4'(m % 10), 3'(m / 10), 4'(hh % 10), 2'(hh / 10), p, w, e};
    endfunction

    always @(negedge clk) begin
        logic [22:0] gotA, gotB, expA, expB;
        gotA = {s_u_a, s_t_a, m_u_a, m_t_a, h_u_a, h_t_a, pm_a, wrap_a, err_a};
        gotB = {s_u_b, s_t_b, m_u_b, m_t_b, h_u_b, h_t_b, pm_b, wrap_b, err_b};
        expA = expVec(tA / 3600, (tA / 60) % 60, tA % 60, mode_12h, wrapA, errA);
        expB = expVec(tB / 60, tB % 60, 0, mode_12h, wrapB, errB);
        total++;
        if (gotA !== expA) begin
            bad++;
            $display("FAIL modelA t=%0t got=%h exp=%h", $time, gotA, expA);
        end
        total++;
        if (gotB !== expB) begin
            bad++;
            $display("FAIL modelB t=%0t got=%h exp=%h", $time, gotB, expB);
        end
    end

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    // Packs the time as hex-readable hhmmss.
    function automatic logic [23:0] bcdA();
        return {2'b00, h_t_a, h_u_a, 1'b0, m_t_a, m_u_a, 1'b0, s_t_a, s_u_a};
    endfunction

    function automatic logic [23:0] bcdB();
        return {2'b00, h_t_b, h_u_b, 1'b0, m_t_b, m_u_b, 1'b0, s_t_b, s_u_b};
    endfunction

    task automatic setRaw(int ht, int hu, int mt, int mu, int st, int su);
        ld_h_t = 2'(ht); ld_h_u = 4'(hu);
        ld_m_t = 3'(mt); ld_m_u = 4'(mu);
        ld_s_t = 3'(st); ld_s_u = 4'(su);
    endtask

    task automatic setLd(int h, int m, int s);
        setRaw(h / 10, h % 10, m / 10, m % 10, s / 10, s % 10);
    endtask

    task automatic cyc(bit e, bit d, bit l);
        #1;
        en = e; dir = d; load = l;
        @(negedge clk);
    endtask

    task automatic setMode(bit md);
        #1;
        mode_12h = md;
        #1;
    endtask

    int bounds[8] = '{95959, 195959, 100000, 200000, 235959, 0, 125959, 130000};

    initial begin
        rst_n = 1'b0; en = 0; dir = 0; load = 0; mode_12h = 0;
        setLd(0, 0, 0);
        #12;
        chk("rstA", {bcdA(), 2'b00, wrap_a, err_a}, {24'h000000, 4'b0000});
        chk("rstB", {bcdB(), 2'b00, wrap_b, err_b}, {24'h070000, 4'b0000});
        #10 rst_n = 1'b1;
        @(negedge clk);

        setLd(23, 59, 58); cyc(0, 0, 1);
        chk("ld235958", bcdA(), 24'h235958);
        cyc(1, 0, 0); chk("up235959", {bcdA(), 3'b0, wrap_a}, {24'h235959, 4'd0});
        cyc(1, 0, 0); chk("upWrap",   {bcdA(), 3'b0, wrap_a}, {24'h000000, 4'd1});
        cyc(1, 0, 0); chk("up000001", {bcdA(), 3'b0, wrap_a}, {24'h000001, 4'd0});

        setLd(0, 0, 0); cyc(0, 0, 1);
        cyc(1, 1, 0); chk("dnWrap",   {bcdA(), 3'b0, wrap_a}, {24'h235959, 4'd1});
        cyc(1, 1, 0); chk("dn235958", {bcdA(), 3'b0, wrap_a}, {24'h235958, 4'd0});

        setRaw(2, 4, 0, 0, 0, 0); cyc(0, 0, 1);
        chk("err24", {bcdA(), 3'b0, err_a}, {24'h235958, 4'd1});
        cyc(0, 0, 0); chk("errDrop", {3'b0, err_a}, 4'd0);
        setRaw(1, 2, 6, 0, 0, 0); cyc(0, 0, 1);
        chk("errMt6", {bcdA(), 3'b0, err_a}, {24'h235958, 4'd1});
        setLd(12, 34, 56); cyc(1, 0, 1);
        chk("ldNoStep", bcdA(), 24'h123456);

        setRaw(0, 9, 5, 9, 6, 0); cyc(0, 0, 1);
        chk("secIllA", {bcdA(), 3'b0, err_a}, {24'h123456, 4'd1});
        chk("secIgnB", {bcdB(), 3'b0, err_b}, {24'h095900, 4'd0});
        cyc(1, 0, 0);
        chk("b1000", bcdB(), 24'h100000);

        setLd(0, 30, 0); cyc(0, 0, 1);
        setMode(1); chk("h12am", {h_t_a, h_u_a, pm_a}, {2'd1, 4'd2, 1'b0});
        setLd(12, 0, 0); cyc(0, 0, 1);
        chk("h12pm", {h_t_a, h_u_a, pm_a}, {2'd1, 4'd2, 1'b1});
        setLd(13, 5, 0); cyc(0, 0, 1);
        chk("h01pm", {h_t_a, h_u_a, pm_a}, {2'd0, 4'd1, 1'b1});
        setMode(0); chk("h13", {h_t_a, h_u_a, pm_a}, {2'd1, 4'd3, 1'b0});
        @(negedge clk);

        foreach (bounds[i]) begin
            setLd(bounds[i] / 10000, (bounds[i] / 100) % 100, bounds[i] % 100);
            cyc(0, 0, 1); cyc(1, 0, 0);
            cyc(0, 0, 1); cyc(1, 1, 0);
        end
        setLd(19, 59, 59); cyc(0, 0, 1); cyc(1, 0, 0);
        chk("up200000", bcdA(), 24'h200000);

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0)
                setRaw($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7),
                       $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15));
            #1 mode_12h = ($urandom_range(0, 1) == 1);
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
        end

        setMode(0);
        setLd(5, 6, 7); cyc(0, 0, 1);
        cyc(1, 0, 0); cyc(1, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("asyncA", {bcdA(), 2'b00, wrap_a, err_a}, {24'h000000, 4'b0000});
        chk("asyncB", {bcdB(), 2'b00, wrap_b, err_b}, {24'h070000, 4'b0000});
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("resumeA", bcdA(), 24'h000001);
        chk("resumeB", bcdB(), 24'h070100);
        cyc(1, 0, 0);
        chk("resumeA2", bcdA(), 24'h000002);
        cyc(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
